// File: rtl/boid_frame_scanner_pkg.sv
// Shared constants and types for the boid bitmap scan-out path: VGA 640x480 timing,
// bitmap grid geometry and the frame FSM encoding.
package boid_frame_scanner_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam int GRID_W     = 32;
  localparam int GRID_H     = 32;
  localparam int CELL_SHIFT = 3;
  localparam int ADDR_WIDTH = 10;

  // Wide enough for 800 columns and 525 lines.
  localparam int CNT_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE,
    SWAP,
    CLEAR
  } frame_state_e;

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel/line counters with raw (unregistered) sync, active and vblank-entry decode.
// Everything advances only on pixel_en ticks.
module vga_timing_counter
  import boid_frame_scanner_pkg::*;
#(
  parameter int H_ACTIVE = boid_frame_scanner_pkg::H_ACTIVE,
  parameter int H_FP     = boid_frame_scanner_pkg::H_FP,
  parameter int H_SYNC   = boid_frame_scanner_pkg::H_SYNC,
  parameter int H_BP     = boid_frame_scanner_pkg::H_BP,
  parameter int V_ACTIVE = boid_frame_scanner_pkg::V_ACTIVE,
  parameter int V_FP     = boid_frame_scanner_pkg::V_FP,
  parameter int V_SYNC   = boid_frame_scanner_pkg::V_SYNC,
  parameter int V_BP     = boid_frame_scanner_pkg::V_BP
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pixel_en,
  output logic [CNT_WIDTH-1:0] hcnt,
  output logic [CNT_WIDTH-1:0] vcnt,
  output logic                 hsync_raw,
  output logic                 vsync_raw,
  output logic                 active_raw,
  output logic                 vblank_entry
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic h_last;
  logic v_last;

  assign h_last = (hcnt == CNT_WIDTH'(H_TOTAL - 1));
  assign v_last = (vcnt == CNT_WIDTH'(V_TOTAL - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of the order the statements are written in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pixel_en) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + CNT_WIDTH'(1);
      end else begin
        hcnt <= hcnt + CNT_WIDTH'(1);
      end
    end
  end

  assign hsync_raw  = !((hcnt >= CNT_WIDTH'(HS_START)) && (hcnt < CNT_WIDTH'(HS_END)));
  assign vsync_raw  = !((vcnt >= CNT_WIDTH'(VS_START)) && (vcnt < CNT_WIDTH'(VS_END)));
  assign active_raw = (hcnt < CNT_WIDTH'(H_ACTIVE)) && (vcnt < CNT_WIDTH'(V_ACTIVE));

  // Strobes on the tick that wraps the last visible line into the first vblank line.
  assign vblank_entry = pixel_en && h_last && (vcnt == CNT_WIDTH'(V_ACTIVE - 1));

endmodule

// File: rtl/boid_frame_scanner.sv
// Scan-out side of the double-buffered boid bitmap: address pipeline that hides the
// 1-clk bitmap read latency, plus the per-frame buffer swap and clear window.
module boid_frame_scanner
  import boid_frame_scanner_pkg::*;
#(
  parameter int H_ACTIVE   = boid_frame_scanner_pkg::H_ACTIVE,
  parameter int H_FP       = boid_frame_scanner_pkg::H_FP,
  parameter int H_SYNC     = boid_frame_scanner_pkg::H_SYNC,
  parameter int H_BP       = boid_frame_scanner_pkg::H_BP,
  parameter int V_ACTIVE   = boid_frame_scanner_pkg::V_ACTIVE,
  parameter int V_FP       = boid_frame_scanner_pkg::V_FP,
  parameter int V_SYNC     = boid_frame_scanner_pkg::V_SYNC,
  parameter int V_BP       = boid_frame_scanner_pkg::V_BP,
  parameter int GRID_W     = boid_frame_scanner_pkg::GRID_W,
  parameter int GRID_H     = boid_frame_scanner_pkg::GRID_H,
  parameter int CELL_SHIFT = boid_frame_scanner_pkg::CELL_SHIFT,
  parameter int ADDR_WIDTH = boid_frame_scanner_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pixel_en,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_data,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  video_active,
  output logic                  pixel_on,
  output logic                  swap_pulse,
  output logic                  clear_en,
  output logic [15:0]           frame_count
);

  logic [CNT_WIDTH-1:0] hcnt;
  logic [CNT_WIDTH-1:0] vcnt;
  logic                 hsync_raw;
  logic                 vsync_raw;
  logic                 active_raw;
  logic                 vblank_entry;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .pixel_en     (pixel_en),
    .hcnt         (hcnt),
    .vcnt         (vcnt),
    .hsync_raw    (hsync_raw),
    .vsync_raw    (vsync_raw),
    .active_raw   (active_raw),
    .vblank_entry (vblank_entry)
  );

  // ---------------- address / video pipeline ----------------
  logic [CNT_WIDTH-1:0]  cell_x;
  logic [CNT_WIDTH-1:0]  cell_y;
  logic                  in_grid;
  logic [ADDR_WIDTH-1:0] grid_addr;

  assign cell_x    = hcnt >> CELL_SHIFT;
  assign cell_y    = vcnt >> CELL_SHIFT;
  assign in_grid   = (cell_x < CNT_WIDTH'(GRID_W)) && (cell_y < CNT_WIDTH'(GRID_H));
  // Modular arithmetic at ADDR_WIDTH keeps the address inside the bitmap by construction.
  assign grid_addr = ADDR_WIDTH'(cell_y) * ADDR_WIDTH'(GRID_W) + ADDR_WIDTH'(cell_x);

  logic in_grid_d;
  logic active_d;
  logic hsync_d;
  logic vsync_d;

  // Stage 1 issues the bitmap read; stage 2 samples read_data one tick later, which is
  // at least 2 clk after the address changed, so the RAM latency is always covered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_addr    <= '0;
      in_grid_d    <= 1'b0;
      active_d     <= 1'b0;
      hsync_d      <= 1'b1;
      vsync_d      <= 1'b1;
      pixel_on     <= 1'b0;
      video_active <= 1'b0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
    end else if (pixel_en) begin
      if (in_grid) read_addr <= grid_addr;
      in_grid_d    <= in_grid;
      active_d     <= active_raw;
      hsync_d      <= hsync_raw;
      vsync_d      <= vsync_raw;
      pixel_on     <= read_data & in_grid_d & active_d;
      video_active <= active_d;
      hsync        <= hsync_d;
      vsync        <= vsync_d;
    end
  end

  // ---------------- frame FSM ----------------
  frame_state_e          state;
  frame_state_e          state_next;
  logic [ADDR_WIDTH-1:0] clear_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    swap_pulse = 1'b0;
    clear_en   = 1'b0;
    unique case (state)
      IDLE:  if (vblank_entry) state_next = SWAP;
      SWAP: begin
        swap_pulse = 1'b1;
        state_next = CLEAR;
      end
      CLEAR: begin
        clear_en = 1'b1;
        if (clear_cnt == '1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Clear window is exactly 2^ADDR_WIDTH clocks: one per bitmap word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_cnt   <= '0;
      frame_count <= '0;
    end else begin
      clear_cnt <= (state == CLEAR) ? clear_cnt + ADDR_WIDTH'(1) : '0;
      if (state == SWAP) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_boid_frame_scanner.sv
// Self-checking bench for boid_frame_scanner using a reduced raster so several frames
// fit in a short run; expectations come from tick-index arithmetic and a window model.
module tb_boid_frame_scanner;

  localparam int HA = 72, HF = 2, HS = 6, HB = 2;
  localparam int VA = 68, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CS = 1, GW = 32, GH = 32, AW = 10;
  localparam int WIN = 1 << AW;
  localparam int BUDGET = 90000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pixel_en = 1'b0;
  logic          read_data = 1'b0;
  logic [AW-1:0] read_addr;
  logic          hsync, vsync, video_active, pixel_on, swap_pulse, clear_en;
  logic [15:0]   frame_count;

  bit ram [WIN];

  boid_frame_scanner #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .GRID_W (GW), .GRID_H (GH), .CELL_SHIFT (CS), .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_en     (pixel_en),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .hsync        (hsync),
    .vsync        (vsync),
    .video_active (video_active),
    .pixel_on     (pixel_on),
    .swap_pulse   (swap_pulse),
    .clear_en     (clear_en),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read bitmap stand-in: data valid one clk after the address.
  always @(posedge clk) read_data <= ram[read_addr];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: tick index since reset, last in-grid address, clk position in the
  // swap/clear window (-1 = none), expected frame count and per-frame tallies.
  longint n;
  int     last_addr;
  int     since;
  int     exp_frames;
  int     entries;
  int     pulses;
  int     ones, hs_low, vs_low;
  int     clk_count;
  bit     mid_done, done;

  function automatic int px(longint j);
    return int'(j % HT);
  endfunction

  function automatic int py(longint j);
    return int'((j / HT) % VT);
  endfunction

  function automatic bit grid_at(int x, int y);
    return ((x >> CS) < GW) && ((y >> CS) < GH);
  endfunction

  function automatic int addr_at(int x, int y);
    return ((y >> CS) * GW + (x >> CS)) % WIN;
  endfunction

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic load_ram(input int mode);
    for (int i = 0; i < WIN; i++) begin
      case (mode)
        0:       ram[i] = (i == 163);
        2:       ram[i] = 1'b1;
        default: ram[i] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic model_reset();
    n = 0; last_addr = 0; since = -1; exp_frames = 0;
    ones = 0; hs_low = 0; vs_low = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_video_active"}, video_active, 0);
    check({tag, "_pixel_on"}, pixel_on, 0);
    check({tag, "_swap_pulse"}, swap_pulse, 0);
    check({tag, "_clear_en"}, clear_en, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_read_addr"}, read_addr, 0);
  endtask

  // Outputs after tick n show the scan position of tick n-2.
  task automatic tick_checks();
    int x, y;
    bit eh, ev, ea, ep;
    eh = 1'b1; ev = 1'b1; ea = 1'b0; ep = 1'b0;
    if (n >= 2) begin
      x  = px(n - 2);
      y  = py(n - 2);
      eh = !(x >= HA + HF && x < HA + HF + HS);
      ev = !(y >= VA + VF && y < VA + VF + VS);
      ea = (x < HA) && (y < VA);
      ep = ram[addr_at(x, y)] && grid_at(x, y) && ea;
    end
    check("hsync", hsync, eh);
    check("vsync", vsync, ev);
    check("video_active", video_active, ea);
    check("pixel_on", pixel_on, ep);
    check("read_addr", read_addr, last_addr);
    if (pixel_on) ones++;
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
  endtask

  task automatic on_entry();
    entries++;
    case (entries)
      1: begin
        check("single_cell_pixels", ones, (1 << CS) * (1 << CS));
        load_ram(1);
      end
      2: begin
        check("hsync_low_ticks", hs_low, HS * VT);
        check("vsync_low_ticks", vs_low, VS * HT);
        load_ram(2);
      end
      3: begin
        check("all_ones_pixels", ones, min_i(GW << CS, HA) * min_i(GH << CS, VA));
        check("hsync_low_ticks", hs_low, HS * VT);
        check("vsync_low_ticks", vs_low, VS * HT);
        load_ram(1);
      end
      default: ;
    endcase
    ones = 0; hs_low = 0; vs_low = 0;
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    #1;
    check("clear_en_async_drop", clear_en, 0);
    check("swap_async_drop", swap_pulse, 0);
    for (int i = 0; i < 6; i++) begin
      pixel_en = 1'(i % 2);
      @(posedge clk);
      #1;
      clk_count++;
      check_reset_outputs("mid_reset");
    end
    @(negedge clk);
    pixel_en = 1'b0;
    reset    = 1'b0;
    model_reset();
    mid_done = 1'b1;
  endtask

  task automatic step(input logic pe);
    int x, y;
    bit entry;
    pixel_en = pe;
    @(posedge clk);
    #1;
    clk_count++;
    if (since >= 0) begin
      since++;
      if (since == 1) exp_frames = (exp_frames + 1) % 65536;
      if (since == WIN + 1) begin
        since = -1;
        if (mid_done) done = 1'b1;
      end
    end
    if (pe) begin
      x = px(n);
      y = py(n);
      if (grid_at(x, y)) last_addr = addr_at(x, y);
      entry = (x == HT - 1) && (y == VA - 1);
      n++;
      tick_checks();
      if (entry && since < 0) begin
        since = 0;
        on_entry();
      end
    end
    check("swap_pulse", swap_pulse, since == 0);
    check("clear_en", clear_en, (since >= 1) && (since <= WIN));
    check("frame_count", frame_count, exp_frames);
    if (swap_pulse) pulses++;
    if (entries == 3 && since == 2) begin
      check("three_frames_count", frame_count, 3);
      check("three_frames_pulses", pulses, 3);
    end
    if (entries == 3 && since == 100 && !mid_done) mid_reset();
  endtask

  initial begin
    entries = 0; pulses = 0; clk_count = 0;
    mid_done = 1'b0; done = 1'b0;
    model_reset();
    load_ram(0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pixel_en = 1'(i % 2);
      @(posedge clk);
      #1;
      clk_count++;
      check_reset_outputs("reset");
    end
    @(negedge clk);
    pixel_en = 1'b0;
    reset    = 1'b0;

    while (!done && clk_count < BUDGET) begin
      step(1'b1);
      step(1'b0);
      if ($urandom_range(0, 7) == 0) step(1'b0);
    end
    check("finished_in_budget", done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
